// File: rtl/slew_lim_pkg.sv
// Shared definitions for the multi-channel slew-rate limiter.
// Optional feature macro: SLEW_LIM_DONE_PULSE_EN (adds per-channel done_pulse output).
package slew_lim_pkg;

  localparam int unsigned NUM_CH_DEF = 4;

  // Channel index width; never below 1 so a single-channel build still has a usable wr_ch.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CH_IDX_W = ch_idx_w(NUM_CH_DEF);

  typedef enum logic [1:0] {HOLD, RISE, FALL} step_dir_e;

endpackage

// File: rtl/slew_lim_ch.sv
// One slew-limited channel: target/step registers, step arithmetic, settled flag and,
// when SLEW_LIM_DONE_PULSE_EN is defined, a one-cycle done pulse after a ramp lands.
module slew_lim_ch
  import slew_lim_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr,
  input  logic              snap,
  input  logic [DATA_W-1:0] wr_tgt,
  input  logic [STEP_W-1:0] wr_up,
  input  logic [STEP_W-1:0] wr_dn,
  output logic [DATA_W-1:0] cur,
  output logic              settled
`ifdef SLEW_LIM_DONE_PULSE_EN
  ,
  output logic              done_pulse
`endif
);

  logic [DATA_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [STEP_W-1:0] up_q, up_d, dn_q, dn_d;
  step_dir_e         dir;
  logic [DATA_W:0]   gap_up, gap_dn, up_ext, dn_ext, step_val;
  logic              reached;

  // Direction and candidate next value; one extra bit keeps cur+up / cur-dn from wrapping.
  always_comb begin
    dir = HOLD;
    if (cur_q < tgt_q) begin
      dir = RISE;
    end else if (cur_q > tgt_q) begin
      dir = FALL;
    end
    gap_up   = {1'b0, tgt_q} - {1'b0, cur_q};
    gap_dn   = {1'b0, cur_q} - {1'b0, tgt_q};
    up_ext   = (DATA_W + 1)'(up_q);
    dn_ext   = (DATA_W + 1)'(dn_q);
    step_val = {1'b0, cur_q};
    unique case (dir)
      RISE:    step_val = (gap_up <= up_ext) ? {1'b0, tgt_q} : {1'b0, cur_q} + up_ext;
      FALL:    step_val = (gap_dn <= dn_ext) ? {1'b0, tgt_q} : {1'b0, cur_q} - dn_ext;
      default: step_val = {1'b0, cur_q};
    endcase
  end

  // Next-state: tick steps toward the currently held target; snap overrides the step.
  always_comb begin
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    up_d    = up_q;
    dn_d    = dn_q;
    reached = 1'b0;
    if (tick && (dir != HOLD)) begin
      cur_d   = step_val[DATA_W-1:0];
      reached = (step_val == {1'b0, tgt_q});
    end
    if (wr) begin
      tgt_d = wr_tgt;
      up_d  = wr_up;
      dn_d  = wr_dn;
      if (snap) begin
        cur_d   = wr_tgt;
        reached = 1'b0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
      tgt_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

`ifdef SLEW_LIM_DONE_PULSE_EN
  logic done_q;

  // Pulse for the single cycle following a tick step that lands on the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= reached;
    end
  end

  assign done_pulse = done_q;
`else
  logic unused_reached;
  assign unused_reached = reached;
`endif

  assign cur     = cur_q;
  assign settled = (cur_q == tgt_q);

endmodule

// File: rtl/slew_limiter_mc.sv
// Multi-channel slew-rate limiter top: tick prescaler, write decode and output packing.
// Optional feature macro: SLEW_LIM_DONE_PULSE_EN (adds done_pulse output, one bit per channel).
module slew_limiter_mc
  import slew_lim_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned STEP_W = 4,
  parameter  int unsigned DIV_W  = 8,
  localparam int unsigned IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_ch,
  input  logic [DATA_W-1:0]        wr_tgt,
  input  logic [STEP_W-1:0]        wr_up,
  input  logic [STEP_W-1:0]        wr_dn,
  input  logic                     wr_snap,
  input  logic [DIV_W-1:0]         div,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        settled,
  output logic                     tick
`ifdef SLEW_LIM_DONE_PULSE_EN
  ,
  output logic [NUM_CH-1:0]        done_pulse
`endif
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_int;

  // Compare against the live div so a new divide value applies at the next compare.
  assign tick_int = ~reset & (cnt_q == div);

  // Prescaler next count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_int) begin
      cnt_d = '0;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = tick_int;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;

    // Out-of-range channel numbers match no instance and are dropped.
    assign hit = wr_en && (wr_ch == IDX_W'(i));

    slew_lim_ch #(
      .DATA_W (DATA_W),
      .STEP_W (STEP_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick_int),
      .wr         (hit),
      .snap       (wr_snap),
      .wr_tgt     (wr_tgt),
      .wr_up      (wr_up),
      .wr_dn      (wr_dn),
      .cur        (data_out[i*DATA_W +: DATA_W]),
      .settled    (settled[i])
`ifdef SLEW_LIM_DONE_PULSE_EN
      ,
      .done_pulse (done_pulse[i])
`endif
    );
  end

endmodule

// File: tb/tb_slew_limiter_mc.sv
// Self-checking bench for slew_limiter_mc: scoreboard of expected ramp values per tick.
// A second 3-channel instance exercises the out-of-range channel write (wr_ch = 3).
module tb_slew_limiter_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_snap;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_tgt;
  logic [3:0]  wr_up, wr_dn;
  logic [7:0]  div;
  logic [31:0] data_out;
  logic [3:0]  settled;
  logic        tick;
  logic [3:0]  done_pulse;

  logic        wr3_en, wr3_snap;
  logic [1:0]  wr3_ch;
  logic [7:0]  wr3_tgt;
  logic [23:0] data3;
  logic [2:0]  settled3;
  logic        tick3;
  logic [2:0]  done3;

  int          checks = 0;
  int          errors = 0;
  logic        pre_tick;
  int          dp_cnt[4];
  logic [7:0]  exp_q[$];

  slew_limiter_mc #(
    .NUM_CH (4), .DATA_W (8), .STEP_W (4), .DIV_W (8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_tgt   (wr_tgt),
    .wr_up    (wr_up),
    .wr_dn    (wr_dn),
    .wr_snap  (wr_snap),
    .div      (div),
    .data_out (data_out),
    .settled  (settled),
    .tick     (tick)
`ifdef SLEW_LIM_DONE_PULSE_EN
    ,
    .done_pulse (done_pulse)
`endif
  );

  slew_limiter_mc #(
    .NUM_CH (3), .DATA_W (8), .STEP_W (4), .DIV_W (8)
  ) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr3_en),
    .wr_ch    (wr3_ch),
    .wr_tgt   (wr3_tgt),
    .wr_up    (4'd1),
    .wr_dn    (4'd1),
    .wr_snap  (wr3_snap),
    .div      (div),
    .data_out (data3),
    .settled  (settled3),
    .tick     (tick3)
`ifdef SLEW_LIM_DONE_PULSE_EN
    ,
    .done_pulse (done3)
`endif
  );

`ifndef SLEW_LIM_DONE_PULSE_EN
  assign done_pulse = '0;
  assign done3      = '0;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] ch_out(input int i);
    return data_out[i*8 +: 8];
  endfunction

  // One clock: remember whether this edge is an update edge, then sample 1 ns after it.
  task automatic step();
    pre_tick = tick;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (done_pulse[i]) dp_cnt[i]++;
  endtask

  task automatic do_write(input int ch, input logic [7:0] tgt, input logic [3:0] up,
                          input logic [3:0] dn, input logic snap);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_tgt  = tgt;
    wr_up   = up;
    wr_dn   = dn;
    wr_snap = snap;
    step();
    wr_en   = 1'b0;
    wr_snap = 1'b0;
  endtask

  task automatic push_ramp(input int start, input int tgt, input int up, input int dn);
    int v = start;
    while (v != tgt) begin
      if (v < tgt) v = (tgt - v <= up) ? tgt : v + up;
      else         v = (v - tgt <= dn) ? tgt : v - dn;
      exp_q.push_back(8'(v));
    end
  endtask

  // Pop one expected value per tick; between ticks the output must not move.
  task automatic drain(input int ch, input logic [7:0] tgt, input int period);
    logic [7:0] prev, e;
    int guard = 0, gap = 0, nticks = 0;
    prev = ch_out(ch);
    while (exp_q.size() > 0 && guard < 2000) begin
      step();
      guard++;
      gap++;
      if (pre_tick) begin
        e = exp_q.pop_front();
        checks++;
        if (ch_out(ch) !== e) begin
          errors++;
          $display("FAIL ramp ch%0d: got %0d expected %0d", ch, ch_out(ch), e);
        end
        checks++;
        if (settled[ch] !== (e == tgt)) begin
          errors++;
          $display("FAIL settled ch%0d at %0d: got %b expected %b", ch, e, settled[ch], e == tgt);
        end
        if (nticks > 0) begin
          checks++;
          if (gap != period) begin
            errors++;
            $display("FAIL tick period: got %0d expected %0d", gap, period);
          end
        end
        nticks++;
        gap  = 0;
        prev = e;
      end else begin
        checks++;
        if (ch_out(ch) !== prev) begin
          errors++;
          $display("FAIL hold off-tick ch%0d: got %0d expected %0d", ch, ch_out(ch), prev);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ramp timeout ch%0d: got %0d left expected 0", ch, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (data_out !== 32'd0 || settled !== 4'hF || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got out=%h settled=%b tick=%b expected 0/1111/0",
               data_out, settled, tick);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL tick div0: got %b expected 1", tick);
    end
  endtask

  task automatic test_rise();
    for (int i = 0; i < 4; i++) dp_cnt[i] = 0;
    do_write(0, 8'd100, 4'd10, 4'd0, 1'b0);
    checks++;
    if (ch_out(0) !== 8'd0) begin
      errors++;
      $display("FAIL rise write-edge hold: got %0d expected 0", ch_out(0));
    end
    push_ramp(0, 100, 10, 0);
    drain(0, 8'd100, 1);
    step();
    step();
`ifdef SLEW_LIM_DONE_PULSE_EN
    checks++;
    if (dp_cnt[0] != 1) begin
      errors++;
      $display("FAIL done_pulse count rise: got %0d expected 1", dp_cnt[0]);
    end
`endif
  endtask

  task automatic test_fall_clamp();
    do_write(1, 8'd100, 4'd0, 4'd0, 1'b1);
    checks++;
    if (ch_out(1) !== 8'd100 || settled[1] !== 1'b1) begin
      errors++;
      $display("FAIL snap ch1: got %0d/%b expected 100/1", ch_out(1), settled[1]);
    end
    do_write(1, 8'd3, 4'd0, 4'd7, 1'b0);
    push_ramp(100, 3, 0, 7);
    drain(1, 8'd3, 1);
  endtask

  task automatic test_prescaler();
    div = 8'd3;
    do_write(2, 8'd20, 4'd5, 4'd0, 1'b0);
    push_ramp(0, 20, 5, 0);
    drain(2, 8'd20, 4);
    div = 8'd0;  // counter is 0 right after a tick, so div=0 matches immediately
  endtask

  task automatic test_snap();
    int e0, e3;
    for (int i = 0; i < 4; i++) dp_cnt[i] = 0;
    do_write(0, 8'd0, 4'd10, 4'd5, 1'b0);
    do_write(3, 8'd200, 4'd10, 4'd0, 1'b0);
    e0 = 95;
    e3 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      e0 -= 5;
      e3 += 10;
      checks++;
      if (ch_out(0) !== 8'(e0) || ch_out(3) !== 8'(e3)) begin
        errors++;
        $display("FAIL parallel ramps: got %0d/%0d expected %0d/%0d",
                 ch_out(0), ch_out(3), e0, e3);
      end
    end
    do_write(3, 8'd7, 4'd10, 4'd0, 1'b1);
    e0 -= 5;
    checks++;
    if (ch_out(3) !== 8'd7 || settled[3] !== 1'b1 || ch_out(0) !== 8'(e0)) begin
      errors++;
      $display("FAIL snap mid-ramp: got ch3=%0d s=%b ch0=%0d expected 7/1/%0d",
               ch_out(3), settled[3], ch_out(0), e0);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      e0 -= 5;
      checks++;
      if (ch_out(3) !== 8'd7 || ch_out(0) !== 8'(e0)) begin
        errors++;
        $display("FAIL after snap: got ch3=%0d ch0=%0d expected 7/%0d", ch_out(3), ch_out(0), e0);
      end
    end
`ifdef SLEW_LIM_DONE_PULSE_EN
    checks++;
    if (dp_cnt[3] != 0) begin
      errors++;
      $display("FAIL done_pulse on snap: got %0d expected 0", dp_cnt[3]);
    end
`endif
  endtask

  task automatic test_write_tick_and_range();
    do_write(0, 8'd30, 4'd4, 4'd0, 1'b1);
    checks++;
    if (ch_out(0) !== 8'd30 || settled[0] !== 1'b1 || tick !== 1'b1) begin
      errors++;
      $display("FAIL ch0 snap 30: got %0d/%b tick=%b expected 30/1/1", ch_out(0), settled[0], tick);
    end
    do_write(0, 8'd50, 4'd4, 4'd0, 1'b0);
    checks++;
    if (ch_out(0) !== 8'd30 || pre_tick !== 1'b1) begin
      errors++;
      $display("FAIL write+tick old target: got %0d expected 30", ch_out(0));
    end
    step();
    checks++;
    if (ch_out(0) !== 8'd34) begin
      errors++;
      $display("FAIL next tick new target: got %0d expected 34", ch_out(0));
    end
    wr3_en = 1'b1; wr3_ch = 2'd2; wr3_tgt = 8'd99; wr3_snap = 1'b1;
    step();
    wr3_ch = 2'd3; wr3_tgt = 8'd55;
    step();
    wr3_en = 1'b0; wr3_snap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (data3 !== {8'd99, 16'd0} || settled3 !== 3'b111) begin
        errors++;
        $display("FAIL out-of-range write: got %h/%b expected 630000/111", data3, settled3);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_write(1, 8'd250, 4'd15, 4'd0, 1'b0);
    step();
    step();
    step();
    checks++;
    if (ch_out(1) !== 8'd48) begin
      errors++;
      $display("FAIL pre-reset ramp: got %0d expected 48", ch_out(1));
    end
    reset = 1'b1;
    step();
    checks++;
    if (data_out !== 32'd0 || settled !== 4'hF || tick !== 1'b0 || done_pulse !== 4'd0) begin
      errors++;
      $display("FAIL reset mid-ramp: got out=%h settled=%b tick=%b expected 0/1111/0",
               data_out, settled, tick);
    end
    reset = 1'b0;
    step();
    step();
    step();
    checks++;
    if (data_out !== 32'd0 || settled !== 4'hF || data3 !== 24'd0) begin
      errors++;
      $display("FAIL ramp resumed: got out=%h settled=%b expected 0/1111", data_out, settled);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_snap = 1'b0; wr_ch = '0; wr_tgt = '0;
    wr_up = '0; wr_dn = '0; div = 8'd0;
    wr3_en = 1'b0; wr3_snap = 1'b0; wr3_ch = '0; wr3_tgt = '0;
    pre_tick = 1'b0;
    for (int i = 0; i < 4; i++) dp_cnt[i] = 0;
    test_reset();
    test_rise();
    test_fall_clamp();
    test_prescaler();
    test_snap();
    test_write_tick_and_range();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
